// File: rtl/pipe_flow_ctrl_pkg.sv
// rtl/pipe_flow_ctrl_pkg.sv - shared word type, NOP constant and flow-controller state enum
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    localparam lc3b_word NOP = 16'h0000;

    // I_WAIT: D side done, waiting on the I-cache; D_WAIT: fetch held, waiting on the D-cache
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        I_WAIT  = 2'b01,
        D_WAIT  = 2'b10,
        ID_WAIT = 2'b11
    } flow_state_t;

    function automatic lc3b_word sat_inc(input lc3b_word value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/pipe_flow_ctrl_if.sv
// rtl/pipe_flow_ctrl_if.sv - hazard, cache handshake and pipeline-register control bundle
interface pipe_flow_ctrl_if;
    import lc3b_types::*;

    logic     gen_bubble;
    logic     squash_ID;
    logic     imem_resp;
    lc3b_word if_ir_in;
    logic     dmem_req;
    logic     dmem_resp;
    logic     imem_read;
    logic     dmem_go;
    logic     pc_load;
    logic     id_ex_load;
    logic     id_ex_nop;
    logic     ex_mem_load;
    logic     mem_wb_load;
    logic     flow_ID_EX;
    lc3b_word if_id_ir;

    modport master (
        input  gen_bubble, squash_ID, imem_resp, if_ir_in, dmem_req, dmem_resp,
        output imem_read, dmem_go, pc_load, id_ex_load, id_ex_nop,
               ex_mem_load, mem_wb_load, flow_ID_EX, if_id_ir
    );

    modport slave (
        output gen_bubble, squash_ID, imem_resp, if_ir_in, dmem_req, dmem_resp,
        input  imem_read, dmem_go, pc_load, id_ex_load, id_ex_nop,
               ex_mem_load, mem_wb_load, flow_ID_EX, if_id_ir
    );

endinterface

// File: rtl/pipe_flow_ctrl_fetch_hold_buf.sv
// rtl/pipe_flow_ctrl_fetch_hold_buf.sv - cache-done flags (as controller state) and fetched-word hold buffer
module fetch_hold_buf
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     advance,
    input  logic     imem_resp,
    input  lc3b_word if_ir_in,
    input  logic     dmem_req,
    input  logic     dmem_resp,
    output logic     i_done,
    output logic     d_done,
    output lc3b_word fetched_word,
    output flow_state_t state
);

    flow_state_t state_q;
    flow_state_t state_next;
    lc3b_word    hold_q;
    logic        i_set;
    logic        d_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_next;
        end
    end

    // A response that arrives without advancing is remembered until the stage finally moves
    always_comb begin
        state_next = state_q;
        i_set      = i_done | imem_resp;
        d_set      = d_done | (dmem_resp & dmem_req);
        if (advance) begin
            state_next = RUN;
        end else begin
            case ({i_set, d_set})
                2'b10:   state_next = D_WAIT;
                2'b01:   state_next = I_WAIT;
                2'b11:   state_next = ID_WAIT;
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= NOP;
        end else if (imem_resp && !advance) begin
            hold_q <= if_ir_in;
        end
    end

    assign i_done       = (state_q == D_WAIT) || (state_q == ID_WAIT);
    assign d_done       = (state_q == I_WAIT) || (state_q == ID_WAIT);
    assign fetched_word = i_done ? hold_q : if_ir_in;
    assign state        = state_q;

endmodule

// File: rtl/pipe_flow_ctrl.sv
// rtl/pipe_flow_ctrl.sv - pipeline advance/stall/bubble control; PIPE_PERF_CNT_EN adds perf counters
module pipe_flow_ctrl
    import lc3b_types::*;
(
    input  logic             clk,
    input  logic             rst_n,
`ifdef PIPE_PERF_CNT_EN
    input  logic             perf_clr,
    output lc3b_word         bubble_cnt,
    output lc3b_word         squash_cnt,
    output lc3b_word         stall_cnt,
`endif
    pipe_flow_ctrl_if.master bus
);

    logic        advance;
    logic        i_done;
    logic        d_done;
    lc3b_word    fetched_word;
    lc3b_word    if_id_ir_q;
    flow_state_t state;

    fetch_hold_buf u_fetch_hold_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .advance      (advance),
        .imem_resp    (bus.imem_resp),
        .if_ir_in     (bus.if_ir_in),
        .dmem_req     (bus.dmem_req),
        .dmem_resp    (bus.dmem_resp),
        .i_done       (i_done),
        .d_done       (d_done),
        .fetched_word (fetched_word),
        .state        (state)
    );

    // Gating with rst_n keeps every strobe low and drops responses seen while reset is held
    assign advance = rst_n & (bus.imem_resp | i_done)
                           & (~bus.dmem_req | bus.dmem_resp | d_done);

    assign bus.flow_ID_EX  = advance;
    assign bus.id_ex_load  = advance;
    assign bus.ex_mem_load = advance;
    assign bus.mem_wb_load = advance;
    assign bus.pc_load     = advance & ~bus.gen_bubble;
    assign bus.id_ex_nop   = advance & (bus.gen_bubble | bus.squash_ID);
    assign bus.imem_read   = rst_n & ~i_done;
    assign bus.dmem_go     = rst_n & bus.dmem_req & ~d_done;
    assign bus.if_id_ir    = if_id_ir_q;

    // Bubble alone re-presents the held instruction; bubble plus squash kills it and refetches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_ir_q <= NOP;
        end else if (advance) begin
            if (bus.gen_bubble && bus.squash_ID) begin
                if_id_ir_q <= NOP;
            end else if (!bus.gen_bubble) begin
                if_id_ir_q <= fetched_word;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= 16'h0000;
            squash_cnt <= 16'h0000;
            stall_cnt  <= 16'h0000;
        end else if (perf_clr) begin
            bubble_cnt <= 16'h0000;
            squash_cnt <= 16'h0000;
            stall_cnt  <= 16'h0000;
        end else begin
            if (advance && bus.gen_bubble) begin
                bubble_cnt <= sat_inc(bubble_cnt);
            end
            if (advance && bus.squash_ID) begin
                squash_cnt <= sat_inc(squash_cnt);
            end
            if (!advance) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb/tb_pipe_flow_ctrl.sv - vector table plus reset/stall corner sequences for pipe_flow_ctrl
module tb_pipe_flow_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    logic [15:0] sb_q[$];

    pipe_flow_ctrl_if bus ();

`ifdef PIPE_PERF_CNT_EN
    logic        perf_clr = 1'b0;
    logic [15:0] bubble_cnt, squash_cnt, stall_cnt;
    logic [15:0] snap_bubble, snap_squash, snap_stall;
`endif

    pipe_flow_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef PIPE_PERF_CNT_EN
        .perf_clr   (perf_clr),
        .bubble_cnt (bubble_cnt),
        .squash_cnt (squash_cnt),
        .stall_cnt  (stall_cnt),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gb, sq, ir, dq, dr;
        logic [15:0] word;
        logic        adv, pcl, nop, imr, dgo;
        logic [15:0] exp_ir;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic gb, sq, ir, dq, dr, input logic [15:0] word);
        bus.gen_bubble = gb;
        bus.squash_ID  = sq;
        bus.imem_resp  = ir;
        bus.dmem_req   = dq;
        bus.dmem_resp  = dr;
        bus.if_ir_in   = word;
    endtask

    initial begin
        logic [15:0] exp_ir;

        //             gb sq ir dq dr word      adv pcl nop imr dgo exp_ir
        vecs[0]  = '{0, 0, 1, 0, 0, 16'h1261, 1, 1, 0, 1, 0, 16'h1261};
        vecs[1]  = '{1, 0, 1, 0, 0, 16'h2222, 1, 0, 1, 1, 0, 16'h1261};
        vecs[2]  = '{0, 1, 1, 0, 0, 16'h3333, 1, 1, 1, 1, 0, 16'h3333};
        vecs[3]  = '{1, 1, 1, 0, 0, 16'h4444, 1, 0, 1, 1, 0, 16'h0000};
        vecs[4]  = '{0, 0, 0, 0, 0, 16'h5555, 0, 0, 0, 1, 0, 16'h0000};
        vecs[5]  = '{1, 1, 0, 0, 0, 16'h5555, 0, 0, 0, 1, 0, 16'h0000};
        vecs[6]  = '{0, 0, 1, 1, 1, 16'h6666, 1, 1, 0, 1, 1, 16'h6666};
        vecs[7]  = '{0, 0, 1, 1, 0, 16'h7777, 0, 0, 0, 1, 1, 16'h6666};
        vecs[8]  = '{0, 0, 0, 1, 0, 16'h8888, 0, 0, 0, 0, 1, 16'h6666};
        vecs[9]  = '{1, 0, 0, 1, 1, 16'h9999, 1, 0, 1, 0, 1, 16'h6666};
        vecs[10] = '{0, 1, 0, 1, 1, 16'haaaa, 0, 0, 0, 1, 1, 16'h6666};
        vecs[11] = '{0, 1, 1, 1, 0, 16'hbbbb, 1, 1, 1, 1, 0, 16'hbbbb};
        vecs[12] = '{0, 0, 1, 1, 0, 16'hc0c0, 0, 0, 0, 1, 1, 16'hbbbb};
        vecs[13] = '{0, 0, 0, 1, 1, 16'hd0d0, 1, 1, 0, 0, 1, 16'hc0c0};

        // Reset held with every response asserted: nothing may load or request
        drive(1, 0, 1, 1, 1, 16'hffff);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_imem_read", {15'd0, bus.imem_read}, 16'd0);
        check("rst_dmem_go",   {15'd0, bus.dmem_go},   16'd0);
        check("rst_pc_load",   {15'd0, bus.pc_load},   16'd0);
        check("rst_flow",      {15'd0, bus.flow_ID_EX}, 16'd0);
        check("rst_if_id_ir",  bus.if_id_ir,           16'h0000);
        drive(0, 0, 0, 0, 0, 16'h0000);
        rst_n = 1'b1;
        #1;
        check("rel_imem_read", {15'd0, bus.imem_read}, 16'd1);
        @(posedge clk);
        #1;

`ifdef PIPE_PERF_CNT_EN
        snap_bubble = bubble_cnt;
        snap_squash = squash_cnt;
        snap_stall  = stall_cnt;
`endif
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].gb, vecs[i].sq, vecs[i].ir, vecs[i].dq, vecs[i].dr, vecs[i].word);
            sb_q.push_back(vecs[i].exp_ir);
            @(negedge clk);
            check($sformatf("v%0d_flow", i),    {15'd0, bus.flow_ID_EX}, {15'd0, vecs[i].adv});
            check($sformatf("v%0d_loads", i),
                  {13'd0, bus.id_ex_load, bus.ex_mem_load, bus.mem_wb_load}, {13'd0, {3{vecs[i].adv}}});
            check($sformatf("v%0d_pc_load", i), {15'd0, bus.pc_load},   {15'd0, vecs[i].pcl});
            check($sformatf("v%0d_nop", i),     {15'd0, bus.id_ex_nop}, {15'd0, vecs[i].nop});
            check($sformatf("v%0d_imem_rd", i), {15'd0, bus.imem_read}, {15'd0, vecs[i].imr});
            check($sformatf("v%0d_dmem_go", i), {15'd0, bus.dmem_go},   {15'd0, vecs[i].dgo});
            @(posedge clk);
            #1;
            exp_ir = sb_q.pop_front();
            check($sformatf("v%0d_if_id_ir", i), bus.if_id_ir, exp_ir);
        end
`ifdef PIPE_PERF_CNT_EN
        check("tbl_bubble_cnt", bubble_cnt - snap_bubble, 16'd3);
        check("tbl_squash_cnt", squash_cnt - snap_squash, 16'd3);
        check("tbl_stall_cnt",  stall_cnt - snap_stall,   16'd6);
        snap_stall = stall_cnt;
`endif

        // D-cache miss: fetch lands in cycle 1, data in cycle 4
        for (int c = 1; c <= 4; c++) begin
            drive(0, 0, c == 1, 1, c == 4, (c == 1) ? 16'h1e1e : 16'hdead);
            @(negedge clk);
            check($sformatf("dmiss_c%0d_imem_rd", c), {15'd0, bus.imem_read}, {15'd0, c == 1});
            check($sformatf("dmiss_c%0d_flow", c),    {15'd0, bus.flow_ID_EX}, {15'd0, c == 4});
            @(posedge clk);
            #1;
        end
        check("dmiss_if_id_ir", bus.if_id_ir, 16'h1e1e);
`ifdef PIPE_PERF_CNT_EN
        check("dmiss_stall_cnt", stall_cnt - snap_stall, 16'd3);
`endif

        // Reset asserted while waiting on the D-cache, with both responses present
        drive(0, 0, 1, 1, 0, 16'h2b2b);
        @(posedge clk);
        #1;
        drive(0, 0, 1, 1, 1, 16'h4d4d);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_flow",      {15'd0, bus.flow_ID_EX}, 16'd0);
        check("midrst_imem_read", {15'd0, bus.imem_read},  16'd0);
        check("midrst_dmem_go",   {15'd0, bus.dmem_go},    16'd0);
        check("midrst_if_id_ir",  bus.if_id_ir,            16'h0000);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 16'h5e5e);
        rst_n = 1'b1;
        #1;
        check("postrst_imem_read", {15'd0, bus.imem_read},  16'd1);
        check("postrst_dmem_go",   {15'd0, bus.dmem_go},    16'd1);
        check("postrst_flow",      {15'd0, bus.flow_ID_EX}, 16'd0);
        @(posedge clk);
        #1;
        check("postrst_hold_ir", bus.if_id_ir, 16'h0000);
        drive(0, 0, 1, 1, 1, 16'h3c3c);
        @(negedge clk);
        check("fresh_flow", {15'd0, bus.flow_ID_EX}, 16'd1);
        @(posedge clk);
        #1;
        check("fresh_if_id_ir", bus.if_id_ir, 16'h3c3c);

`ifdef PIPE_PERF_CNT_EN
        // Stall counter saturation, then clear taking priority over a same-cycle stall
        drive(0, 0, 0, 0, 0, 16'h0000);
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        check("clr_stall_cnt", stall_cnt, 16'h0000);
        repeat (65540) @(posedge clk);
        #1;
        check("sat_stall_cnt", stall_cnt, 16'hFFFF);
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        check("clr_prio_stall",  stall_cnt,  16'h0000);
        check("clr_prio_bubble", bubble_cnt, 16'h0000);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
